// File: rtl/tiny_cpu_sequencer.sv
// tiny_cpu_sequencer: upstream instruction source for TinyCPU.
//
// Holds a small program of 12-bit words ({opcode[11:8], imm[7:0]}) and presents them in
// order on TinyCPU's In bus. Each word is held for HoldCycles clocks. A run ends when the
// latched length is reached or when the next word carries the HaltOp opcode; a halt word
// is never presented.
//
// Optional feature: define STEP_MODE_EN to add step_i. In that build the hold counter is
// ignored during a run and the sequencer advances only on clock edges where step_i is 1.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset (program memory is not reset)
//   load_en_i      write load_data_i to program memory at load_addr_i (ignored while running)
//   load_addr_i    program write address
//   load_data_i    program word
//   prog_len_i     number of words to execute (0..2**Aw), sampled on start_i
//   start_i        begin a run from address 0 (ignored while running)
//   abort_i        stop the run and return to idle; beats start_i and load_en_i
//   step_i         (STEP_MODE_EN only) advance to the next word
//   instr_o        word driven to TinyCPU In; 12'h000 (clear op) when not running
//   instr_valid_o  instr_o is a program word
//   pc_o           address of the word on instr_o
//   busy_o         a run is in progress
//   done_o         run completed; held until the next start or abort
module tiny_cpu_sequencer #(
  parameter int unsigned Aw         = 4,
  parameter int unsigned HoldCycles = 4,
  parameter logic [3:0]  HaltOp     = 4'hF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_en_i,
  input  logic [Aw-1:0] load_addr_i,
  input  logic [11:0]   load_data_i,
  input  logic [Aw:0]   prog_len_i,
  input  logic          start_i,
  input  logic          abort_i,
`ifdef STEP_MODE_EN
  input  logic          step_i,
`endif
  output logic [11:0]   instr_o,
  output logic          instr_valid_o,
  output logic [Aw-1:0] pc_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned Depth = 2 ** Aw;
  localparam int unsigned HcW   = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

  localparam logic [HcW-1:0] HoldInit = HcW'(HoldCycles - 1);
  localparam logic [HcW-1:0] HoldOne  = HcW'(1);
  localparam logic [Aw-1:0]  PcOne    = Aw'(1);
  localparam logic [Aw:0]    LenOne   = (Aw + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [11:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [Aw-1:0]   pc_q, pc_d;
  logic            done_q, done_d;
  logic [HcW-1:0]  hold_q, hold_d;
  logic [Aw:0]     len_q, len_d;

  logic [11:0]     mem_q [Depth];
  logic            mem_we;

  logic [Aw-1:0]   pc_next;
  logic [11:0]     word_next;
  logic            advance;
  logic            run_end;

  assign pc_next   = pc_q + PcOne;
  assign word_next = mem_q[pc_next];

`ifdef STEP_MODE_EN
  assign advance = step_i;
`else
  assign advance = (hold_q == '0);
`endif

  // pc_next wraps only when pc_q is the last address, which is then also the last word.
  assign run_end = ({1'b0, pc_q} == (len_q - LenOne)) || (word_next[11:8] == HaltOp);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    done_d  = done_q;
    hold_d  = hold_q;
    len_d   = len_q;
    mem_we  = 1'b0;

    if (abort_i) begin
      state_d = StIdle;
      instr_d = 12'h000;
      valid_d = 1'b0;
      done_d  = 1'b0;
      pc_d    = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          mem_we = load_en_i;
          if (start_i) begin
            len_d = prog_len_i;
            pc_d  = '0;
            if ((prog_len_i == '0) || (mem_q[0][11:8] == HaltOp)) begin
              state_d = StDone;
              instr_d = 12'h000;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StRun;
              instr_d = mem_q[0];
              valid_d = 1'b1;
              done_d  = 1'b0;
              hold_d  = HoldInit;
            end
          end
        end
        StRun: begin
          if (!advance) begin
            hold_d = hold_q - HoldOne;
          end else if (run_end) begin
            state_d = StDone;
            instr_d = 12'h000;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_next;
            instr_d = word_next;
            hold_d  = HoldInit;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      instr_q <= 12'h000;
      valid_q <= 1'b0;
      pc_q    <= '0;
      done_q  <= 1'b0;
      hold_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
    end
  end

  // Program memory survives reset so a program can be re-run after a reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign busy_o        = (state_q == StRun);
  assign done_o        = done_q;

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
module tb_tiny_cpu_sequencer;

  localparam int Hold = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        load_en_i;
  logic [3:0]  load_addr_i;
  logic [11:0] load_data_i;
  logic [4:0]  prog_len_i;
  logic        start_i;
  logic        abort_i;
`ifdef STEP_MODE_EN
  logic        step_i;
`endif
  logic [11:0] instr_o;
  logic        instr_valid_o;
  logic [3:0]  pc_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] tb_mem [16];
  logic [18:0] exp_q [$];   // {done, busy, valid, pc, instr}

  tiny_cpu_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_en_i    (load_en_i),
    .load_addr_i  (load_addr_i),
    .load_data_i  (load_data_i),
    .prog_len_i   (prog_len_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
`ifdef STEP_MODE_EN
    .step_i       (step_i),
`endif
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [18:0] stat();
    return {done_o, busy_o, instr_valid_o, pc_o, instr_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [11:0] data);
    load_en_i   = 1'b1;
    load_addr_i = addr[3:0];
    load_data_i = data;
    @(negedge clk_i);
    load_en_i   = 1'b0;
    tb_mem[addr] = data;
  endtask

  // Expected stream: each word up to len or the first halt opcode, Hold cycles apiece.
  function automatic int build_exp(input int len);
    int n = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (tb_mem[i][11:8] == 4'hF) break;
      for (int k = 0; k < Hold; k++) exp_q.push_back({1'b0, 1'b1, 1'b1, i[3:0], tb_mem[i]});
      n++;
    end
    return n;
  endfunction

  // meddle: two cycles in, try a load at addr 1 and a second start; both must be ignored.
  task automatic run(input string tag, input int len, input bit meddle);
    int n_words;
    int idx = 0;
    logic [18:0] e;
    n_words    = build_exp(len);
    prog_len_i = len[4:0];
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_word%0d", tag, idx), 32'(stat()), 32'(e));
      if (meddle && idx == 2) begin
        load_en_i   = 1'b1;
        load_addr_i = 4'd1;
        load_data_i = 12'h555;
        start_i     = 1'b1;
      end
      @(negedge clk_i);
      load_en_i = 1'b0;
      start_i   = 1'b0;
      idx++;
    end
    check({tag, "_done"}, 32'({done_o, busy_o, instr_valid_o, instr_o}), 32'({3'b100, 12'h000}));
    if (n_words > 0) check({tag, "_pc_hold"}, 32'(pc_o), n_words - 1);
    repeat (3) @(negedge clk_i);
    check({tag, "_done_held"}, 32'({done_o, busy_o}), 32'b10);
  endtask

  initial begin
    rst_ni      = 1'b0;
    load_en_i   = 1'b0;
    load_addr_i = '0;
    load_data_i = '0;
    prog_len_i  = '0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
`ifdef STEP_MODE_EN
    step_i      = 1'b0;
`endif
    #3;
    check("reset_state", 32'(stat()), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Zero-length run: straight to done, never busy.
    run("len0", 0, 1'b0);

`ifndef STEP_MODE_EN
    // Eight-word program.
    load(0, 12'h000); load(1, 12'h107); load(2, 12'h208); load(3, 12'h400);
    load(4, 12'h900); load(5, 12'hB00); load(6, 12'h600); load(7, 12'h300);
    run("prog8", 8, 1'b0);

    // Load and start during a run are ignored; re-run shows the original word at 1.
    run("meddle", 8, 1'b1);
    run("rerun", 8, 1'b0);

    // Halt opcode at address 2 ends the run after two words.
    load(0, 12'h107); load(1, 12'h208); load(2, 12'hF00); load(3, 12'h400);
    run("halt", 4, 1'b0);

    // Abort during a run.
    prog_len_i = 5'd4;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    repeat (5) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort", 32'(stat()), 32'h0);

    // Full-depth program: pc reaches 15 without wrapping.
    for (int i = 0; i < 16; i++) load(i, 12'h100 + 12'(i));
    run("full16", 16, 1'b0);

    // Asynchronous reset mid-run, mid-clock; memory survives.
    prog_len_i = 5'd16;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check("async_reset", 32'(stat()), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run("after_reset", 16, 1'b0);
`else
    // Step mode: words change only on step edges.
    load(0, 12'h107); load(1, 12'h208); load(2, 12'h400);
    prog_len_i = 5'd3;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    check("step_w0", 32'(stat()), 32'({3'b011, 4'd0, 12'h107}));
    for (int s = 0; s < 3; s++) begin
      repeat (10) @(negedge clk_i);
      check($sformatf("step_hold%0d", s), 32'(instr_o), 32'(tb_mem[s]));
      step_i = 1'b1;
      @(negedge clk_i);
      step_i = 1'b0;
      if (s < 2) check($sformatf("step_w%0d", s + 1), 32'(stat()),
                       32'({3'b011, 4'(s + 1), tb_mem[s + 1]}));
      else check("step_done", 32'({done_o, busy_o, instr_valid_o, instr_o}),
                 32'({3'b100, 12'h000}));
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort", 32'(stat()), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
